// File: rtl/count_capture_compare.sv
// Period detection, registered compare and handshaked event capture for an up-counter's cnt bus.
// Define COUNT_CAPTURE_COMPARE_SYNC_EN to route capture through a 2-flop synchronizer.
module count_capture_compare #(
    parameter int Width   = 4,
    parameter int CmpMode = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] cnt,
    input  logic             cnt_en,
    input  logic [Width-1:0] period,
    input  logic [Width-1:0] cmp,
    input  logic             capture,
    input  logic             cap_ack,
    input  logic             ovr_clr,
    output logic             cnt_reset,
    output logic             tc,
    output logic             cmp_out,
    output logic [Width-1:0] cap_data,
    output logic             cap_valid,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        FULL
    } cap_state_t;

    logic             at_terminal;
    logic             tc_reg;
    logic             cmp_next;
    logic             cmp_reg;
    logic             capture_q;
    logic             capture_prev_reg;
    logic             reset_d_reg;
    logic             cap_edge;
    cap_state_t       cap_state_reg;
    logic [Width-1:0] cap_data_reg;
    logic             cap_valid_reg;
    logic             overrun_reg;

    // The counter clears together with this block, then on every terminal count.
    assign at_terminal = cnt_en && (cnt == period);
    assign cnt_reset   = reset | at_terminal;

    always_ff @(posedge clock) begin
        if (reset) begin
            tc_reg <= 1'b0;
        end else begin
            tc_reg <= at_terminal;
        end
    end

    always_comb begin
        cmp_next = 1'b0;
        case (CmpMode)
            1:       cmp_next = (cnt == cmp);
            2:       cmp_next = (cnt <= cmp);
            3:       cmp_next = (cnt > cmp);
            default: cmp_next = (cnt < cmp);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmp_reg <= 1'b0;
        end else begin
            cmp_reg <= cmp_next;
        end
    end

`ifdef COUNT_CAPTURE_COMPARE_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], capture};
        end
    end

    assign capture_q = sync_reg[1];
`else
    assign capture_q = capture;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            capture_prev_reg <= 1'b0;
        end else begin
            capture_prev_reg <= capture_q;
        end
        reset_d_reg <= reset;
    end

    // History is cleared by reset, so the first post-reset cycle is masked to keep a
    // level that was already high at release from looking like a rising edge.
    assign cap_edge = capture_q & ~capture_prev_reg & ~reset_d_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_state_reg <= IDLE;
            cap_data_reg  <= '0;
            cap_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            case (cap_state_reg)
                IDLE: begin
                    if (cap_edge) begin
                        cap_data_reg  <= cnt;
                        cap_state_reg <= FULL;
                        cap_valid_reg <= 1'b1;
                    end
                end
                FULL: begin
                    if (cap_ack) begin
                        if (cap_edge) begin
                            cap_data_reg <= cnt;
                        end else begin
                            cap_state_reg <= IDLE;
                            cap_valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    cap_state_reg <= IDLE;
                    cap_valid_reg <= 1'b0;
                end
            endcase

            // An unacknowledged slot keeps the oldest sample; a new overrun beats a clear.
            if ((cap_state_reg == FULL) && !cap_ack && cap_edge) begin
                overrun_reg <= 1'b1;
            end else if (ovr_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign tc        = tc_reg;
    assign cmp_out   = cmp_reg;
    assign cap_data  = cap_data_reg;
    assign cap_valid = cap_valid_reg;
    assign overrun   = overrun_reg;

endmodule
